// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor.
// The operation is split into STAGES = WIDTH/BLOCK slices; slice k is resolved
// in pipeline stage k using the carry registered by stage k-1. Operands travel
// down the pipe with their partial result so every slice sees its own
// operation, and the whole pipe advances or holds as a unit.
//
// Handshake: an input transfers on a rising edge when In_Valid && In_Ready;
// a result transfers when Out_Valid && Out_Ready. In_Ready is the pipe advance
// condition (!Out_Valid || Out_Ready), so a stalled output freezes every stage
// and Sum/Cout/Ovf stay stable while Out_Valid is held.
module csa_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic             Sub,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int STAGES = WIDTH / BLOCK;

   // Per-stage pipeline state. Element k holds the output of stage k.
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q    [STAGES];
   logic [WIDTH-1:0]  a_d    [STAGES];
   logic [WIDTH-1:0]  beff_q [STAGES];
   logic [WIDTH-1:0]  beff_d [STAGES];
   logic [WIDTH-1:0]  sum_q  [STAGES];
   logic [WIDTH-1:0]  sum_d  [STAGES];
   logic              ovf_q, ovf_d;

   logic              advance;

   // Whole-pipe advance condition; doubles as the input ready.
   always_comb begin
      advance  = !valid_q[STAGES-1] || Out_Ready;
      In_Ready = advance;
   end

   // Slice datapath: each stage adds its slice with carry-in 0 and 1, then
   // selects with the carry from the previous stage.
   always_comb begin : stage_logic
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             v_in;
      logic [BLOCK-1:0] a_sl;
      logic [BLOCK-1:0] b_sl;
      logic [BLOCK:0]   r0;
      logic [BLOCK:0]   r1;
      a_in    = '0;
      b_in    = '0;
      s_in    = '0;
      c_in    = 1'b0;
      v_in    = 1'b0;
      a_sl    = '0;
      b_sl    = '0;
      r0      = '0;
      r1      = '0;
      valid_d = '0;
      carry_d = '0;
      ovf_d   = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k]    = '0;
         beff_d[k] = '0;
         sum_d[k]  = '0;
      end
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            // Subtract is A + ~B + 1, so the external carry is ignored then.
            a_in = A;
            b_in = B ^ {WIDTH{Sub}};
            c_in = Sub | Cin;
            v_in = In_Valid;
            s_in = '0;
         end else begin
            a_in = a_q[k-1];
            b_in = beff_q[k-1];
            c_in = carry_q[k-1];
            v_in = valid_q[k-1];
            s_in = sum_q[k-1];
         end
         a_sl = a_in[k*BLOCK +: BLOCK];
         b_sl = b_in[k*BLOCK +: BLOCK];
         r0   = {1'b0, a_sl} + {1'b0, b_sl};
         r1   = {1'b0, a_sl} + {1'b0, b_sl} + {{BLOCK{1'b0}}, 1'b1};

         valid_d[k] = v_in;
         a_d[k]     = a_in;
         beff_d[k]  = b_in;
         sum_d[k]   = s_in;
         sum_d[k][k*BLOCK +: BLOCK] = c_in ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
         carry_d[k] = c_in ? r1[BLOCK] : r0[BLOCK];
      end
      // Signed overflow is resolved in the last stage, where the top slice and
      // the operand sign bits of the same operation are all available.
      ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
              (sum_d[STAGES-1][WIDTH-1] != a_in[WIDTH-1]);
   end

   // Pipeline registers: cleared asynchronously, shifted only on advance.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= '0;
            beff_q[k] <= '0;
            sum_q[k]  <= '0;
         end
      end else if (advance) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]    <= a_d[k];
            beff_q[k] <= beff_d[k];
            sum_q[k]  <= sum_d[k];
         end
      end
   end

   // Output view of the last stage.
   always_comb begin
      Out_Valid = valid_q[STAGES-1];
      Sum       = sum_q[STAGES-1];
      Cout      = carry_q[STAGES-1];
      Ovf       = ovf_q;
   end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder (WIDTH=16, BLOCK=4, four-cycle latency).
// Inputs change 1 time unit after the rising edge; transfers are observed on
// the falling edge, where the handshake signals for the coming edge are stable.
module tb_csa_pipe_adder;

  localparam int W = 16;
  localparam int LAT = 4;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         In_Valid;
  logic         In_Ready;
  logic         Sub;
  logic         Cin;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Out_Valid;
  logic         Out_Ready = 1'b1;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  csa_pipe_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Sub       (Sub),
    .Cin       (Cin),
    .A         (A),
    .B         (B),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // ---------------- counters and scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  logic [W+1:0] exp_q[$];   // {sum, cout, ovf}
  int           lat_q[$];   // issue cycle, or -1 when latency is not checked

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: two's-complement add/subtract with signed overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         ovf;
    beff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return {full[W-1:0], full[W], ovf};
  endfunction

  // ---------------- backpressure driver ----------------
  int bp_mode = 0;  // 0: always ready, 1: never ready, 2: random
  always @(posedge Clk) begin
    #1;
    case (bp_mode)
      0:       Out_Ready = 1'b1;
      1:       Out_Ready = 1'b0;
      default: Out_Ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  logic         held_v = 1'b0;
  logic [W+1:0] held;
  logic [W+1:0] mon_e;
  int           mon_t;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      held_v = 1'b0;
    end else begin
      chk("in_ready", In_Ready, (!Out_Valid || Out_Ready));
      if (held_v) begin
        chk("hold_valid", Out_Valid, 1'b1);
        chk("hold_data", {Sum, Cout, Ovf}, held);
      end
      held_v = Out_Valid && !Out_Ready;
      held   = {Sum, Cout, Ovf};
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out at t=%0t: got %0h, expected no result", $time, {Sum, Cout, Ovf});
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = lat_q.pop_front();
          chk("result", {Sum, Cout, Ovf}, mon_e);
          if (mon_t >= 0) chk("latency", cyc - mon_t, LAT);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input logic [W+1:0] exp, input bit push, input bit lat);
    int  waits = 0;
    bit  done  = 0;
    A = a; B = b; Sub = sub; Cin = cin; In_Valid = 1'b1;
    while (!done) begin
      @(negedge Clk);
      if (In_Ready) begin
        done = 1;
        if (push) begin
          exp_q.push_back(exp);
          lat_q.push_back(lat ? cyc : -1);
        end
      end else if (++waits > 200) begin
        done = 1;
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout at t=%0t: got In_Ready=0 for %0d cycles, expected acceptance", $time, waits);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic issue_rand(input bit lat);
    logic [W-1:0] a, b;
    logic         s, c;
    a = W'($urandom);
    b = W'($urandom);
    s = 1'($urandom_range(0, 1));
    c = 1'($urandom_range(0, 1));
    issue(a, b, s, c, model(a, b, s, c), 1, lat);
  endtask

  task automatic idle(input int n);
    In_Valid = 1'b0;
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic drain();
    int waits = 0;
    In_Valid = 1'b0;
    while (exp_q.size() != 0 && waits < 200) begin
      @(posedge Clk); #1;
      waits++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout at t=%0t: got %0d results pending, expected 0", $time, exp_q.size());
    end
    idle(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0; In_Valid = 1'b0; Sub = 1'b0; Cin = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_out_valid", Out_Valid, 1'b0);
    chk("reset_sum", Sum, 16'h0000);
    chk("reset_cout", Cout, 1'b0);
    chk("reset_ovf", Ovf, 1'b0);
    Reset_n = 1'b1;
    #1;
    chk("reset_in_ready", In_Ready, 1'b1);
    @(posedge Clk); #1;

    // Directed vectors, back-to-back, latency checked.
    issue(16'hFFFF, 16'h0001, 0, 0, {16'h0000, 1'b1, 1'b0}, 1, 1);
    issue(16'h0005, 16'h0007, 1, 0, {16'hFFFE, 1'b0, 1'b0}, 1, 1);
    issue(16'h0007, 16'h0005, 1, 0, {16'h0002, 1'b1, 1'b0}, 1, 1);
    issue(16'h7FFF, 16'h0001, 0, 0, {16'h8000, 1'b0, 1'b1}, 1, 1);
    issue(16'h1234, 16'h0FFF, 0, 1, {16'h2234, 1'b0, 1'b0}, 1, 1);
    issue(16'h8000, 16'h0001, 1, 0, {16'h7FFF, 1'b1, 1'b1}, 1, 1);
    issue(16'h0000, 16'h0000, 1, 0, {16'h0000, 1'b1, 1'b0}, 1, 1);
    issue(16'h0005, 16'h0007, 1, 1, {16'hFFFE, 1'b0, 1'b0}, 1, 1);
    issue(16'h00FF, 16'h0F01, 0, 0, {16'h1000, 1'b0, 1'b0}, 1, 1);
    drain();

    // Throughput: eight back-to-back ops, each must emerge exactly LAT later.
    for (int i = 0; i < 8; i++) issue_rand(1);
    // Mid-stream stall of a few cycles while the stream keeps coming.
    fork
      begin
        for (int i = 0; i < 8; i++) issue_rand(0);
      end
      begin
        repeat (4) @(posedge Clk);
        bp_mode = 1;
        repeat (3) @(posedge Clk);
        bp_mode = 0;
      end
    join
    drain();

    // Reset mid-flight: three ops in the pipe are discarded.
    issue(16'h1111, 16'h2222, 0, 0, '0, 0, 0);
    issue(16'h3333, 16'h4444, 0, 0, '0, 0, 0);
    issue(16'h5555, 16'h6666, 1, 0, '0, 0, 0);
    In_Valid = 1'b0;
    Reset_n  = 1'b0;
    #1;
    chk("midreset_out_valid", Out_Valid, 1'b0);
    chk("midreset_sum", Sum, 16'h0000);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    idle(8);
    issue(16'h4321, 16'h1234, 0, 0, {16'h5555, 1'b0, 1'b0}, 1, 1);
    drain();

    // Random sweep with random gaps and random backpressure.
    bp_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      issue_rand(0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 0;
    drain();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
